reg_file: RTL

Parametrised general-purpose register file, successor to the single 32-bit register.
- Depth and width are set by parameters; 1 write port with byte enables; 2 combinational read ports.
- Optional hardwired zero register and optional write-to-read bypass.
- Per-register pending-write scoreboard, so the CPU pipeline can detect RAW hazards on in-flight results.

---
 rtl/reg_file.sv | 112 +++++++++++
 1 files changed

// File: rtl/reg_file.sv
// reg_file: parametrised general-purpose register file.
//
// One write port with per-byte enables and two combinational read ports.
// Register 0 can be hardwired to zero (ZERO_REG). A write can be forwarded
// to a read port in the same cycle (BYPASS). A pending-write scoreboard
// holds one busy bit per register so the pipeline can detect RAW hazards.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   regWrite, writeAddr,    write strobe, index, data and per-byte enable
//   writeData, writeByteEn  (bit i covers writeData[8i+7:8i])
//   readAddrA/readDataA     read port A (combinational)
//   readAddrB/readDataB     read port B (combinational)
//   busyMark, busyAddr      set the pending-write bit of busyAddr
//   busyA, busyB            pending-write flag for each read address
//   anyBusy                 OR of all registered pending bits
module reg_file #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter bit                     ZERO_REG    = 1'b1,
  parameter bit                     BYPASS      = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      regWrite,
  input  logic [ADDR_WIDTH-1:0]     writeAddr,
  input  logic [DATA_WIDTH-1:0]     writeData,
  input  logic [DATA_WIDTH/8-1:0]   writeByteEn,
  input  logic [ADDR_WIDTH-1:0]     readAddrA,
  output logic [DATA_WIDTH-1:0]     readDataA,
  input  logic [ADDR_WIDTH-1:0]     readAddrB,
  output logic [DATA_WIDTH-1:0]     readDataB,
  input  logic                      busyMark,
  input  logic [ADDR_WIDTH-1:0]     busyAddr,
  output logic                      busyA,
  output logic                      busyB,
  output logic                      anyBusy
);

  localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busyNext;

  logic [DATA_WIDTH-1:0] wrMask;
  logic [DATA_WIDTH-1:0] mergedWrite;
  logic                  doWrite;
  logic                  bypassA;
  logic                  bypassB;
  logic                  retireA;
  logic                  retireB;

  for (genvar g = 0; g < NUM_BYTES; g++) begin : genMask
    assign wrMask[8*g +: 8] = {8{writeByteEn[g]}};
  end

  // Stored word with enabled lanes replaced; shared by the write path and
  // the bypass path so both see exactly the same merged value.
  assign mergedWrite = (regs[writeAddr] & ~wrMask) | (writeData & wrMask);
  assign doWrite     = regWrite && !(ZERO_REG && (writeAddr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: RESET_VALUE};
    end else if (doWrite) begin
      regs[writeAddr] <= mergedWrite;
    end
  end

  // Mark is applied after the retiring clear, so a new producer issued in
  // the same cycle as the old one retires leaves the bit set.
  always_comb begin
    busyNext = busy;
    if (regWrite) begin
      busyNext[writeAddr] = 1'b0;
    end
    if (busyMark && !(ZERO_REG && (busyAddr == '0))) begin
      busyNext[busyAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign bypassA = BYPASS && regWrite && !reset && (writeAddr == readAddrA);
  assign bypassB = BYPASS && regWrite && !reset && (writeAddr == readAddrB);

  assign readDataA = (ZERO_REG && (readAddrA == '0)) ? '0 :
                     bypassA ? mergedWrite : regs[readAddrA];
  assign readDataB = (ZERO_REG && (readAddrB == '0)) ? '0 :
                     bypassB ? mergedWrite : regs[readAddrB];

  // A retiring write hides the busy bit early, unless a fresh mark to the
  // same register arrives in that cycle.
  assign retireA = BYPASS && regWrite && (writeAddr == readAddrA) &&
                   !(busyMark && (busyAddr == readAddrA));
  assign retireB = BYPASS && regWrite && (writeAddr == readAddrB) &&
                   !(busyMark && (busyAddr == readAddrB));

  assign busyA   = busy[readAddrA] && !retireA;
  assign busyB   = busy[readAddrB] && !retireB;
  assign anyBusy = |busy;

endmodule
